// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer:
// stall bus encodings, MEM-stage exception codes and the exception vector.
package pipe_ctrl_pkg;

  // Stall bus: bit i stops stage i (0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB)
  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam stall_bus_t STALL_NONE = {NO_STOP, NO_STOP, NO_STOP, NO_STOP, NO_STOP, NO_STOP};
  localparam stall_bus_t STALL_IF   = {NO_STOP, NO_STOP, NO_STOP, NO_STOP, STOP,    STOP};
  localparam stall_bus_t STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP,    STOP,    STOP};
  localparam stall_bus_t STALL_EX   = {NO_STOP, NO_STOP, STOP,    STOP,    STOP,    STOP};
  // WB is left running so the instruction leaving MEM becomes a bubble
  localparam stall_bus_t STALL_MEM  = {NO_STOP, STOP,    STOP,    STOP,    STOP,    STOP};
  localparam stall_bus_t STALL_ALL  = {STOP,    STOP,    STOP,    STOP,    STOP,    STOP};

  // MEM-stage exception codes
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd1;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_ERET = 5'd14;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc0_0380;

  typedef enum logic [1:0] {
    EXC_CLASS_NONE   = 2'd0,
    EXC_CLASS_VECTOR = 2'd1,
    EXC_CLASS_ERET   = 2'd2
  } exc_class_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Classify an exception code; unknown nonzero codes go to the vector
  function automatic exc_class_e exc_classify(input logic [4:0] code);
    exc_class_e cls;
    case (code)
      EXC_NONE: cls = EXC_CLASS_NONE;
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
      EXC_BP, EXC_RI, EXC_OV: cls = EXC_CLASS_VECTOR;
      EXC_ERET: cls = EXC_CLASS_ERET;
      default: cls = EXC_CLASS_VECTOR;
    endcase
    return cls;
  endfunction

  // Priority encoder: the deepest requesting stage determines the stall vector
  function automatic stall_bus_t stall_decode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    stall_bus_t s;
    if (req_mem) begin
      s = STALL_MEM;
    end else if (req_ex) begin
      s = STALL_EX;
    end else if (req_id) begin
      s = STALL_ID;
    end else if (req_if) begin
      s = STALL_IF;
    end else begin
      s = STALL_NONE;
    end
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Debug support for the stall sequencer: consecutive-stall watchdog with a
// sticky timeout flag, plus a saturating count of all stalled cycles.
module pipe_ctrl_stall_watchdog #(
  parameter int unsigned MAX_STALL = 1024,
  parameter int unsigned CNT_W     = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stalled,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_STALL - 1);

  logic [CNT_W-1:0] run_cnt_r;
  logic             timeout_r;
  logic [31:0]      cycles_r;

  // Track consecutive stalled cycles, latch the timeout, count total stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_r <= {CNT_W{1'b0}};
      timeout_r <= 1'b0;
      cycles_r  <= 32'd0;
    end else if (stalled) begin
      if (run_cnt_r != RUN_MAX) begin
        run_cnt_r <= run_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        run_cnt_r <= run_cnt_r;
      end
      // The flag rises on the same edge the run counter reaches MAX_STALL
      timeout_r <= timeout_r | (run_cnt_r >= RUN_LAST);
      if (cycles_r != 32'hffff_ffff) begin
        cycles_r <= cycles_r + 32'd1;
      end else begin
        cycles_r <= cycles_r;
      end
    end else begin
      run_cnt_r <= {CNT_W{1'b0}};
      timeout_r <= timeout_r;
      cycles_r  <= cycles_r;
    end
  end

  assign stall_timeout = timeout_r;
  assign stall_cycles  = cycles_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Stall requests are
// priority-encoded combinationally; a MEM-stage exception freezes the whole
// pipe for one cycle and is followed by a single-cycle flush with redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int unsigned MAX_STALL  = 1024,
  parameter int unsigned CNT_W      = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic [4:0]         excepttype,
  input  logic [31:0]        cp0_epc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               stall_timeout,
  output logic [31:0]        stall_cycles
);

  state_e      state_r;
  logic        flush_r;
  logic [31:0] new_pc_r;
  exc_class_e  exc_class_s;
  stall_bus_t  req_stall_s;
  stall_bus_t  stall_s;
  logic        stalled_s;

  // Decode the incoming exception and stall requests
  always_comb begin
    exc_class_s = exc_classify(excepttype);
    req_stall_s = stall_decode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
  end

  // Drive the stall bus: freeze everything on exception, nothing during flush
  always_comb begin
    stall_s = STALL_NONE;
    if (rst) begin
      stall_s = STALL_NONE;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (exc_class_s != EXC_CLASS_NONE) begin
            stall_s = STALL_ALL;
          end else begin
            stall_s = req_stall_s;
          end
        end
        ST_FLUSH: stall_s = STALL_NONE;
        default:  stall_s = STALL_NONE;
      endcase
    end
  end

  // Sequencer FSM: RUN -> FLUSH on exception, FLUSH -> RUN after one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_RUN;
      flush_r  <= 1'b0;
      new_pc_r <= 32'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (exc_class_s != EXC_CLASS_NONE) begin
            state_r <= ST_FLUSH;
            flush_r <= 1'b1;
            if (exc_class_s == EXC_CLASS_ERET) begin
              new_pc_r <= cp0_epc;
            end else begin
              new_pc_r <= EXC_VECTOR;
            end
          end else begin
            state_r  <= ST_RUN;
            flush_r  <= 1'b0;
            new_pc_r <= new_pc_r;
          end
        end
        ST_FLUSH: begin
          state_r  <= ST_RUN;
          flush_r  <= 1'b0;
          new_pc_r <= new_pc_r;
        end
        default: begin
          state_r  <= ST_RUN;
          flush_r  <= 1'b0;
          new_pc_r <= new_pc_r;
        end
      endcase
    end
  end

  assign stalled_s = (stall_s != STALL_NONE);
  assign stall     = stall_s;
  assign flush     = flush_r;
  assign new_pc    = new_pc_r;

  pipe_ctrl_stall_watchdog #(
    .MAX_STALL(MAX_STALL),
    .CNT_W    (CNT_W)
  ) u_stall_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stalled      (stalled_s),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles)
  );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests and the exception/ERET request from the MEM stage.
- Drives the shared stall bus, flush and redirect PC that every pipeline register consumes.
- Also provides a stall watchdog and a saturating stall-cycle performance counter for debug.

Parameters:
- EXC_VECTOR, 32'hbfc0_0380, redirect target for every exception except ERET.
- MAX_STALL, 1024, consecutive-stall-cycle threshold that sets the watchdog flag.
- CNT_W, 11, width of the consecutive-stall counter; must satisfy 2^CNT_W > MAX_STALL.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- stallreq_if  in  1  IF stage waiting on instruction SRAM.
- stallreq_id  in  1  ID load-use hazard.
- stallreq_ex  in  1  EX multi-cycle mul/div busy.
- stallreq_mem  in  1  MEM stage waiting on data SRAM.
- excepttype  in  5  MEM-stage exception code; 0 means none.
- cp0_epc  in  32  EPC value, used when excepttype is ERET.
- stall  out  6  stall bus; bit i=1 stops stage i (0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB).
- flush  out  1  clear all pipeline registers.
- new_pc  out  32  redirect target, valid while flush=1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  32  saturating count of cycles with stall!=0.

Behaviour:
- Reset (synchronous, active-high; clk/rst fixed as decided):
  - state=RUN; stall=0; flush=0; new_pc=0; stall_timeout=0; stall_cycles=0; run counter=0.
  - A reset asserted mid-FREEZE or mid-FLUSH aborts the sequence, with no flush pulse afterwards.
- Exception codes, from the shared package:
  - NONE=0, INT=1, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12, ERET=14.
  - Any other nonzero code is treated as a generic exception that redirects to EXC_VECTOR.
- RUN state, no exception:
  - Stall is combinational from the requests, highest stage wins: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 0.
  - The WB stall bit is never set in RUN, so mem stall yields a WB bubble (stall[4]=1, stall[5]=0).
  - flush=0.
- RUN state, excepttype!=0 (exception beats all stall requests):
  - Same cycle: stall=6'b111111, which freezes the excepting instruction in MEM.
  - Latch new_pc = (excepttype==ERET) ? cp0_epc : EXC_VECTOR.
  - Next state = FLUSH.
- FLUSH state, exactly 1 cycle:
  - flush=1, stall=0, new_pc holds the latched value.
  - All stall requests and excepttype are ignored.
  - Next state = RUN unconditionally.
- new_pc keeps its last latched value outside FLUSH.
- Back-to-back: an exception visible in the first RUN cycle after FLUSH starts a new sequence normally.
- Watchdog:
  - The run counter increments each cycle stall!=0 and clears when stall==0.
  - FREEZE cycles count as stall; FLUSH cycles do not.
  - When the counter reaches MAX_STALL, stall_timeout sets and stays set until rst; the counter saturates.
- stall_cycles increments every cycle stall!=0 and saturates at 32'hffff_ffff.
- Latency:
  - Stall decode: 0 cycles.
  - Exception to flush: 1 cycle, i.e. exception in cycle T gives flush in T+1.

Decomposition:
- Shared defines/package:
  - StallBus width 6 and Stop/NoStop encodings.
  - Exception-code constants above.
  - EXC_VECTOR default.
  - Stall vector constants STALL_IF/ID/EX/MEM/ALL.
- One natural sub-module: stall_watchdog, containing the run counter, stall_timeout and stall_cycles, fed by a single "stalled" bit.
- FSM and stall priority encoder stay in pipe_ctrl.

Test Plan:
- Each request alone for 1 cycle: if -> stall=6'b000011; id -> 6'b000111; ex -> 6'b001111; mem -> 6'b011111; flush=0, and stall_cycles increments by 1 each time.
- All four requests together -> stall=6'b011111; stall[5]=0 is checked so that WB receives a bubble.
- excepttype=12 together with stallreq_mem=1 in cycle T:
  - T: stall=6'b111111.
  - T+1: flush=1, stall=0, new_pc=32'hbfc0_0380.
  - T+2: flush=0 and stall follows the requests again.
- excepttype=14 with cp0_epc=32'hbfc0_1234 -> T+1: flush=1, new_pc=32'hbfc0_1234; an excepttype=8 presented during FLUSH is ignored (no second flush at T+2).
- With MAX_STALL=8, hold stallreq_ex for 7 cycles -> stall_timeout=0; drop the request, then hold it again for 8 cycles -> stall_timeout=1 and it stays 1 after the request drops.
- Assert rst during the FREEZE cycle -> next cycle stall=0, flush=0, new_pc=0, counters=0, and no flush pulse afterwards.
